// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order write-back queue feeding the register file write port, with decode forwarding
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     alu_valid_i,
    input  logic [4:0]               alu_rd_i,
    input  logic [XLEN-1:0]          alu_data_i,
    output logic                     alu_ready_o,
    input  logic                     mem_valid_i,
    input  logic [4:0]               mem_rd_i,
    input  logic [XLEN-1:0]          mem_data_i,
    output logic                     mem_ready_o,
    input  logic                     wb_stall_i,
    output logic                     RegWrite_o,
    output logic [4:0]               Write_Register_o,
    output logic [XLEN-1:0]          Write_data_o,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    output logic                     fwd1_hit_o,
    output logic [XLEN-1:0]          fwd1_data_o,
    output logic                     fwd2_hit_o,
    output logic [XLEN-1:0]          fwd2_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pop, space, acc_mem, acc_alu, push;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_data;

    // Drain, arbitration (loads win) and push decision; reset silences every handshake
    always_comb begin
        pop         = !reset_i && count_q != '0 && !wb_stall_i;
        space       = count_q < CW'(DEPTH) || pop;
        mem_ready_o = !reset_i && space;
        alu_ready_o = !reset_i && space && !mem_valid_i;
        acc_mem     = mem_valid_i && mem_ready_o;
        acc_alu     = alu_valid_i && alu_ready_o;
        in_rd       = acc_mem ? mem_rd_i : alu_rd_i;
        in_data     = acc_mem ? mem_data_i : alu_data_i;
        push        = (acc_mem || acc_alu) && in_rd != 5'd0;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
    end

    // Register file port driven straight from the head entry
    always_comb begin
        RegWrite_o       = pop;
        Write_Register_o = (!reset_i && count_q != '0) ? rd_q[rd_ptr_q] : 5'd0;
        Write_data_o     = (!reset_i && count_q != '0) ? data_q[rd_ptr_q] : '0;
        count_o          = count_q;
    end

    // Forwarding: scan oldest to youngest so the youngest match overwrites earlier ones
    always_comb begin
        fwd1_hit_o  = 1'b0;
        fwd1_data_o = '0;
        fwd2_hit_o  = 1'b0;
        fwd2_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && !reset_i) begin
                if (rs1_i != 5'd0 && rd_q[rd_ptr_q + AW'(i)] == rs1_i) begin
                    fwd1_hit_o  = 1'b1;
                    fwd1_data_o = data_q[rd_ptr_q + AW'(i)];
                end
                if (rs2_i != 5'd0 && rd_q[rd_ptr_q + AW'(i)] == rs2_i) begin
                    fwd2_hit_o  = 1'b1;
                    fwd2_data_o = data_q[rd_ptr_q + AW'(i)];
                end
            end
        end
    end

    // Pointers and occupancy; reset drops every queued entry
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset since occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= in_rd;
            data_q[wr_ptr_q] <= in_data;
        end
    end
endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side front end for the core's 32x32 register file: the writer that drives its single write port (register index, data, write enable).
- Accepts write-back requests from two producers, the single-cycle ALU path and the multi-cycle load path, and holds them in a small in-order queue.
- Drains one entry per cycle into the register file unless stalled.
- Provides forwarding data and a pending flag for the two decode-stage read indices, so reads never return stale register-file contents while writes are queued.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- XLEN, 32, data width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- alu_valid_i  in  1  ALU write-back request.
- alu_rd_i  in  5  ALU destination index.
- alu_data_i  in  XLEN  ALU result.
- alu_ready_o  out  1  ALU request accepted this cycle.
- mem_valid_i  in  1  load write-back request.
- mem_rd_i  in  5  load destination index.
- mem_data_i  in  XLEN  load data.
- mem_ready_o  out  1  load request accepted this cycle.
- wb_stall_i  in  1  blocks draining; register-file port unavailable.
- RegWrite_o  out  1  write enable to register file.
- Write_Register_o  out  5  write index.
- Write_data_o  out  XLEN  write data.
- rs1_i  in  5  decode read index 1.
- rs2_i  in  5  decode read index 2.
- fwd1_hit_o  out  1  rs1_i matches a queued entry.
- fwd1_data_o  out  XLEN  data of youngest matching entry for rs1_i, else 0.
- fwd2_hit_o  out  1  same, for rs2_i.
- fwd2_data_o  out  XLEN  same, for rs2_i.
- count_o  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- State: circular buffer of DEPTH entries {rd, data}, rd_ptr, wr_ptr, count.
- Reset (reset_i=1 at an edge): pointers and count go to 0; all queued entries are discarded, including mid-drain.
  - Entries are not required to be cleared.
  - While reset_i=1, combinationally force: RegWrite_o=0, Write_Register_o=0, Write_data_o=0, fwd*_hit_o=0, fwd*_data_o=0, alu_ready_o=0, mem_ready_o=0.
- Drain (combinational from head): pop = (count!=0) && !wb_stall_i.
  - RegWrite_o=pop; Write_Register_o and Write_data_o = head entry when count!=0, else 0.
  - rd_ptr advances on pop.
- Accept and arbitration: space = (count < DEPTH) || pop; space counts a same-cycle pop.
  - Load path has fixed priority: mem_ready_o = space.
  - alu_ready_o = space && !mem_valid_i.
  - At most one push per cycle. A producer holds valid and payload until its ready is seen high.
- x0 writes: a request with rd==0 is accepted under the normal ready rule but is not enqueued (no push, count unchanged).
- Push: the accepted nonzero-rd request is written at wr_ptr; wr_ptr advances.
- count next = count + push - pop. Pointers wrap modulo DEPTH.
- Latency: a request accepted in cycle N into an empty queue with no stall gives RegWrite_o=1 in cycle N+1. The register file holds the value from the edge ending N+1.
- Full: count==DEPTH with wb_stall_i=1 → both readies 0. Full with no stall → push and pop in the same cycle; count stays DEPTH.
- Forwarding (combinational):
  - Compare rs1_i and rs2_i against all occupied entries, including the head being written this cycle.
  - On multiple matches, the youngest entry (closest to wr_ptr) wins.
  - rsX_i==0 never hits.
  - New requests in the same cycle are not forwarded.
- Ordering: entries are written to the register file strictly in acceptance order. Duplicate rd entries are all written, oldest first.

Test Plan:
- Reset then idle → RegWrite_o=0, count_o=0, all hits 0; alu_valid_i=1 during reset_i=1 → alu_ready_o=0, nothing queued.
- alu_valid_i=1, rd=5, data=0xDEADBEEF, one cycle, no stall → next cycle RegWrite_o=1, Write_Register_o=5, Write_data_o=0xDEADBEEF; following cycle count_o=0.
- wb_stall_i=1; push rd=3/0x11, rd=7/0x22, rd=3/0x33, rd=9/0x44 → count_o=4, both readies 0; rs1_i=3 → fwd1_hit_o=1, fwd1_data_o=0x33; rs2_i=0 → fwd2_hit_o=0. Release stall → writes in order 3,7,3,9.
- mem_valid_i and alu_valid_i asserted together (rd 4 and rd 6) → mem accepted first, alu_ready_o=0 that cycle; alu accepted next cycle; writes go rd 4 then rd 6.
- Push rd=0, data=0xFFFFFFFF → alu_ready_o=1, count_o unchanged, no RegWrite_o pulse.
- Queue holding 3 entries under stall, reset_i=1 for one cycle → count_o=0 after the edge, no RegWrite_o ever issued for the discarded entries.
